// File: rtl/mp_add_seq.sv
// Multi-precision adder: one N-bit ripple adder is reused to add WORDS*N-bit operands, LS chunk first.
// Define MP_ADD_OVF_EN to add the signed-overflow output ovf.
module mp_add_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] sum,
    output logic               cout,
    output logic               busy
`ifdef MP_ADD_OVF_EN
    ,
    output logic               ovf
`endif
);

    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, b_q;
    logic [W-1:0]    sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            last;
    logic [N-1:0]    chunk_a, chunk_b, s;
    logic            co;
`ifdef MP_ADD_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    assign last = (idx_q == IW'(WORDS - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags come straight from the state register, never from in_valid/out_ready.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
    end

    // The shared adder: selected chunk pair plus the carry held from the previous chunk.
    always_comb begin
        chunk_a = a_q[idx_q*N +: N];
        chunk_b = b_q[idx_q*N +: N];
        {co, s} = {1'b0, chunk_a} + {1'b0, chunk_b} + {{N{1'b0}}, carry_q};
    end

    always_comb begin
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef MP_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                sum_d   = '0;
                idx_d   = '0;
                carry_d = cin;
            end
            RUN: begin
                sum_d[idx_q*N +: N] = s;
                carry_d             = co;
                if (last) begin
                    cout_d = co;
`ifdef MP_ADD_OVF_EN
                    ovf_d  = (a_q[W-1] == b_q[W-1]) && (s[N-1] != a_q[W-1]);
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: if (out_ready) begin
`ifdef MP_ADD_OVF_EN
                ovf_d = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef MP_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef MP_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Operand latches need no reset; they are only read after an acceptance loads them.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && in_valid) begin
            a_q <= a;
            b_q <= b;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef MP_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
